// File: rtl/im_cm_req_pkg.sv
// Shared types and constants for the IM-side CM request initiator (im_cm_req).
package im_cm_req_pkg;

  localparam int unsigned AwDefault = 4;

  // One-hot direction encoding {L,E,N,W,S} = bits {4,3,2,1,0}
  typedef logic [4:0] dir_t;
  localparam dir_t DirS = 5'b00001;
  localparam dir_t DirW = 5'b00010;
  localparam dir_t DirN = 5'b00100;
  localparam dir_t DirE = 5'b01000;
  localparam dir_t DirL = 5'b10000;

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRel} im_state_t;

endpackage

// File: rtl/im_cm_req_if.sv
// Flit input, CM request/grant and flit output bundle between an IM input port and the CM side.
interface im_cm_req_if #(
  parameter int unsigned KN = 5,
  parameter int unsigned DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_head;
  logic          in_tail;
  logic          in_ready;
  logic [KN-1:0] cms;
  logic [4:0]    dir_req;
  logic [KN-1:0] cm_sel;
  logic          req_vld;
  logic          cm_gnt;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_tail;
  logic          out_ready;

  modport master (
    input  in_data, in_valid, in_head, in_tail, cms, cm_gnt, out_ready,
    output in_ready, dir_req, cm_sel, req_vld, out_data, out_valid, out_tail
  );

  modport slave (
    output in_data, in_valid, in_head, in_tail, cms, cm_gnt, out_ready,
    input  in_ready, dir_req, cm_sel, req_vld, out_data, out_valid, out_tail
  );
endinterface

// File: rtl/im_cm_req_xy_dec.sv
// Combinational XY route decode: X dimension first, then Y, local when both match.
module im_cm_req_xy_dec
  import im_cm_req_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned X  = 0,
  parameter int unsigned Y  = 0
) (
  input  logic [2*AW-1:0] dst_i,
  output dir_t            dir_o
);
  localparam logic [AW-1:0] LocX = AW'(X);
  localparam logic [AW-1:0] LocY = AW'(Y);

  logic [AW-1:0] dst_x, dst_y;
  assign dst_x = dst_i[AW-1:0];
  assign dst_y = dst_i[2*AW-1:AW];

  always_comb begin
    if (dst_x > LocX)      dir_o = DirE;
    else if (dst_x < LocX) dir_o = DirW;
    else if (dst_y > LocY) dir_o = DirN;
    else if (dst_y < LocY) dir_o = DirS;
    else                   dir_o = DirL;
  end
endmodule

// File: rtl/im_cm_req.sv
// IM-side CM request initiator: decode head, pick a CM, 4-phase request, stream packet to CM.
// Define IM_CRRD_EN for round-robin CM dispatch; otherwise lowest-index free CM wins.
module im_cm_req
  import im_cm_req_pkg::*;
#(
  parameter int unsigned KN = 5,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = AwDefault,
  parameter int unsigned X  = 0,
  parameter int unsigned Y  = 0
) (
  input logic         clk,
  input logic         rst,
  im_cm_req_if.master bus
);
  localparam int unsigned PtrW = (KN > 1) ? $clog2(KN) : 1;

  im_state_t     state_q, state_d;
  logic [DW-1:0] flit_q, flit_d;
  logic          vld_q, vld_d;
  logic          tail_q, tail_d;
  dir_t          dir_q, dir_d, dir_dec;
  logic [KN-1:0] sel_q, sel_d;
  logic [KN-1:0] pick, mask, hi;
  logic [PtrW-1:0] offset;
  logic          in_rdy;
  logic          out_vld;

  im_cm_req_xy_dec #(
    .AW (AW),
    .X  (X),
    .Y  (Y)
  ) u_xy_dec (
    .dst_i (bus.in_data[2*AW-1:0]),
    .dir_o (dir_dec)
  );

  // CM pick: first free CM at or above offset, else wrap to lowest free CM.
  always_comb begin
    for (int unsigned i = 0; i < KN; i++) begin
      mask[i] = (PtrW'(i) >= offset);
    end
  end
  assign hi   = bus.cms & mask;
  assign pick = (|hi) ? (hi & (~hi + KN'(1))) : (bus.cms & (~bus.cms + KN'(1)));

`ifdef IM_CRRD_EN
  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StReq && bus.cm_gnt) begin
      for (int unsigned k = 0; k < KN; k++) begin
        if (sel_q[k]) ptr_d = (k == KN - 1) ? '0 : PtrW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign offset = ptr_q;
`else
  assign offset = '0;
`endif

  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    vld_d   = vld_q;
    tail_d  = tail_q;
    dir_d   = dir_q;
    sel_d   = sel_q;
    in_rdy  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && bus.in_head && (|bus.cms)) begin
          in_rdy  = 1'b1;
          flit_d  = bus.in_data;
          tail_d  = bus.in_tail;
          vld_d   = 1'b1;
          dir_d   = dir_dec;
          sel_d   = pick;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.cm_gnt) state_d = StXfer;
      end
      StXfer: begin
        // Once the tail is held, stop consuming so the next head stays in the buffer.
        if (vld_q && tail_q) begin
          if (bus.out_ready) begin
            vld_d   = 1'b0;
            state_d = StRel;
          end
        end else if (bus.out_ready || !vld_q) begin
          in_rdy = 1'b1;
          vld_d  = bus.in_valid;
          if (bus.in_valid) begin
            flit_d = bus.in_data;
            tail_d = bus.in_tail;
          end
        end
      end
      StRel: begin
        if (!bus.cm_gnt) begin
          state_d = StIdle;
          dir_d   = '0;
          sel_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      flit_q  <= '0;
      vld_q   <= 1'b0;
      tail_q  <= 1'b0;
      dir_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      vld_q   <= vld_d;
      tail_q  <= tail_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
    end
  end

  assign out_vld       = vld_q && (state_q == StXfer);
  assign bus.in_ready  = in_rdy;
  assign bus.dir_req   = dir_q;
  assign bus.cm_sel    = sel_q;
  assign bus.req_vld   = (state_q == StReq) || (state_q == StXfer);
  assign bus.out_data  = flit_q;
  assign bus.out_valid = out_vld;
  assign bus.out_tail  = out_vld && tail_q;
endmodule

// File: tb/tb_im_cm_req.sv
// Bench for im_cm_req: directed packet scenarios and randomized packets against a packet-level model.
module tb_im_cm_req;
  localparam int unsigned KN = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned X  = 1;
  localparam int unsigned Y  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ptr_m  = 0;

  always #5 clk = ~clk;

  im_cm_req_if #(.KN(KN), .DW(DW)) bus ();

  im_cm_req #(
    .KN (KN),
    .DW (DW),
    .AW (AW),
    .X  (X),
    .Y  (Y)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_dir(input int dx, input int dy);
    if (dx > int'(X)) return 5'b01000;
    if (dx < int'(X)) return 5'b00010;
    if (dy > int'(Y)) return 5'b00100;
    if (dy < int'(Y)) return 5'b00001;
    return 5'b10000;
  endfunction

  // Index of the CM chosen for availability c, scanning upward from the model pointer.
  function automatic int model_pick(input logic [KN-1:0] c);
    for (int i = 0; i < int'(KN); i++) begin
      int j;
      j = (ptr_m + i) % int'(KN);
      if (c[j]) return j;
    end
    return 0;
  endfunction

  task automatic idle_inputs();
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_head   = 1'b0;
    bus.in_tail   = 1'b0;
    bus.cms       = '0;
    bus.cm_gnt    = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // rmode: 0 random out_ready, 1 toggling 1,0,1,0..., 2 always ready. abort >= 0 resets at that beat.
  task automatic run_pkt(input int len, input int dx, input int dy, input logic [KN-1:0] cv,
                         input int gdly, input int rmode, input int abort);
    logic [DW-1:0] f [$];
    logic [AW-1:0] ax, ay;
    logic [4:0]    edir;
    logic [KN-1:0] esel;
    int            sidx, idx, op, cyc, n;
    logic          pop;
    ax = AW'(dx);
    ay = AW'(dy);
    f.push_back({ay, ax});
    for (int i = 1; i < len; i++) f.push_back(DW'($urandom));
    edir = model_dir(dx, dy);
    sidx = model_pick(cv);
    esel = KN'(1) << sidx;

    bus.in_valid = 1'b1; bus.in_head = 1'b1; bus.in_tail = (len == 1); bus.in_data = f[0];
    bus.cms = cv; bus.cm_gnt = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("head_accept", bus.in_ready, 1);
    tick();

    for (int c = 0; c <= gdly; c++) begin
      bus.in_head  = 1'b0;
      bus.in_valid = (len > 1);
      bus.in_tail  = (len == 2);
      if (len > 1) bus.in_data = f[1];
      bus.cms    = KN'($urandom);
      bus.cm_gnt = (c == gdly);
      #1;
      chk("req_vld", bus.req_vld, 1);
      chk("dir_req", bus.dir_req, edir);
      chk("cm_sel", bus.cm_sel, esel);
      chk("req_in_ready", bus.in_ready, 0);
      chk("req_out_valid", bus.out_valid, 0);
      tick();
    end
`ifdef IM_CRRD_EN
    ptr_m = (sidx + 1) % int'(KN);
`endif

    idx = 1;
    op  = 0;
    for (cyc = 0; cyc < 400 && op < len; cyc++) begin
      if (op == abort) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req_vld", bus.req_vld, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_cm_sel", bus.cm_sel, 0);
        ptr_m = 0;
        return;
      end
      if (rmode == 0)      bus.out_ready = ($urandom_range(0, 1) == 1);
      else if (rmode == 1) bus.out_ready = (cyc % 2 == 0);
      else                 bus.out_ready = 1'b1;
      bus.in_valid = (idx < len) && ($urandom_range(0, 3) != 0);
      bus.in_head  = 1'b0;
      bus.in_tail  = (idx == len - 1);
      if (idx < len) bus.in_data = f[idx];
      bus.cm_gnt = ($urandom_range(0, 3) != 0);
      #1;
      if (cyc == 0) chk("first_out_valid", bus.out_valid, 1);
      chk("xfer_req_vld", bus.req_vld, 1);
      if (bus.out_valid) begin
        chk("out_data", bus.out_data, f[op]);
        chk("out_tail", bus.out_tail, (op == len - 1));
        if (op != len - 1) chk("xfer_in_ready", bus.in_ready, bus.out_ready);
      end
      pop = bus.out_valid && bus.out_ready;
      if (bus.in_valid && bus.in_ready) idx++;
      if (pop) op++;
      tick();
    end
    chk("pkt_done", op, len);

    // Release: a waiting head must not be taken until the grant has returned to zero.
    bus.in_valid = 1'b1; bus.in_head = 1'b1; bus.in_tail = 1'b0; bus.in_data = '0;
    bus.cms = '1; bus.out_ready = 1'b1;
    n = $urandom_range(1, 3);
    for (int c = 0; c < n; c++) begin
      bus.cm_gnt = (c < n - 1);
      #1;
      chk("rel_req_vld", bus.req_vld, 0);
      chk("rel_in_ready", bus.in_ready, 0);
      chk("rel_out_valid", bus.out_valid, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_head  = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_dir_req", bus.dir_req, 0);
    chk("rst_cm_sel0", bus.cm_sel, 0);
    chk("rst_req_vld0", bus.req_vld, 0);
    chk("rst_out_valid0", bus.out_valid, 0);
    chk("rst_out_tail", bus.out_tail, 0);
    chk("rst_out_data", bus.out_data, 0);

    // East route, single free CM, grant after three cycles.
    run_pkt(3, 3, 1, 5'b00100, 3, 2, -1);
    // Local single-flit packet.
    run_pkt(1, 1, 1, 5'b01000, 1, 2, -1);
    // Four flits with toggling downstream ready.
    run_pkt(4, 1, 3, 5'b10001, 0, 1, -1);

    // No CM free: head must wait.
    bus.in_valid = 1'b1; bus.in_head = 1'b1; bus.in_tail = 1'b0; bus.in_data = 8'h10;
    bus.cms = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("nocm_in_ready", bus.in_ready, 0);
      chk("nocm_req_vld", bus.req_vld, 0);
      tick();
    end
    run_pkt(2, 0, 1, 5'b00010, 1, 2, -1);

    // Fresh reset, then three back-to-back packets with every CM free.
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m = 0;
    run_pkt(1, 1, 0, 5'b11111, 0, 2, -1);
    run_pkt(2, 1, 0, 5'b11111, 0, 2, -1);
    run_pkt(1, 1, 0, 5'b11111, 0, 2, -1);

    // Reset while the second flit is in flight, then a normal packet.
    run_pkt(4, 2, 2, 5'b00110, 0, 2, 1);
    run_pkt(3, 0, 0, 5'b00110, 2, 0, -1);

    for (int p = 0; p < 25; p++) begin
      run_pkt($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 3),
              KN'($urandom_range(1, 31)), $urandom_range(0, 3), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
